// File: rtl/bus_port_adapter_if.sv
// Bus-side connection between one bus generator/arbiter port and its
// bus_port_adapter endpoint.
//   pndng  : adapter -> bus, TX FIFO holds at least one packet
//   D_pop  : adapter -> bus, TX FIFO head (zero when empty)
//   pop    : bus -> adapter, bus consumes the TX head this cycle
//   push   : bus -> adapter, D_push is delivered this cycle
//   D_push : bus -> adapter, delivered packet
// modport slave is the adapter view, modport master is the bus view.
interface bus_port_adapter_if #(
  parameter int pckg_sz = 16
);
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;

  modport slave (
    output pndng,
    output D_pop,
    input  pop,
    input  push,
    input  D_push
  );

  modport master (
    input  pndng,
    input  D_pop,
    output pop,
    output push,
    output D_push
  );
endinterface

// File: rtl/bus_port_adapter.sv
// Per-device bus endpoint: a TX FIFO feeding the bus through the
// pndng/pop/D_pop handshake, and an RX FIFO filled from push/D_push
// after destination-ID filtering.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   tx_wr, tx_data   : device write into the TX FIFO
//   tx_full          : TX FIFO holds depth entries
//   rx_rd            : device consumes the RX head
//   rx_data          : RX head, zero when empty
//   rx_valid/rx_full : RX FIFO non-empty / holds depth entries
//   tx_ovf_cnt       : TX writes dropped on full (saturating)
//   rx_drop_cnt      : accepted RX packets dropped on full (saturating)
//   rx_misroute_cnt  : RX packets dropped on ID mismatch (saturating)
//   bus              : bus handshake (slave modport)
module bus_port_adapter #(
  parameter int          pckg_sz   = 16,
  parameter int          depth     = 8,
  parameter logic [7:0]  drv_id    = 8'd0,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  input  logic               rx_rd,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_full,
  output logic [15:0]        tx_ovf_cnt,
  output logic [15:0]        rx_drop_cnt,
  output logic [15:0]        rx_misroute_cnt,
  bus_port_adapter_if.slave  bus
);
  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];

  logic [AW-1:0] tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [AW-1:0] rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [15:0]   tx_ovf_q, tx_ovf_d, rx_drop_q, rx_drop_d, rx_mis_q, rx_mis_d;

  logic tx_empty, tx_pop_ok, tx_wr_ok;
  logic rx_empty, rx_rd_ok, rx_wr_ok, rx_id_ok, rx_acc;
  logic [7:0] rx_dest;

  assign tx_empty  = (tx_cnt_q == '0);
  assign tx_full   = (tx_cnt_q == FULL_CNT);
  assign tx_pop_ok = bus.pop && !tx_empty;
  // A write into a full FIFO still lands when the head leaves on the same edge.
  assign tx_wr_ok  = tx_wr && (!tx_full || tx_pop_ok);

  assign rx_dest  = bus.D_push[pckg_sz-1 -: 8];
  assign rx_id_ok = (rx_dest == drv_id) || (rx_dest == broadcast);
  assign rx_acc   = bus.push && rx_id_ok;
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_rd_ok = rx_rd && !rx_empty;
  assign rx_wr_ok = rx_acc && (!rx_full || rx_rd_ok);

  assign bus.pndng = !tx_empty;
  assign bus.D_pop = tx_empty ? '0 : tx_mem[tx_rd_q];
  assign rx_valid  = !rx_empty;
  assign rx_data   = rx_empty ? '0 : rx_mem[rx_rd_q];

  assign tx_ovf_cnt      = tx_ovf_q;
  assign rx_drop_cnt     = rx_drop_q;
  assign rx_misroute_cnt = rx_mis_q;

  always_comb begin
    tx_rd_d   = tx_rd_q;
    tx_wr_d   = tx_wr_q;
    rx_rd_d   = rx_rd_q;
    rx_wr_d   = rx_wr_q;
    if (tx_pop_ok) tx_rd_d = tx_rd_q + AW'(1);
    if (tx_wr_ok)  tx_wr_d = tx_wr_q + AW'(1);
    if (rx_rd_ok)  rx_rd_d = rx_rd_q + AW'(1);
    if (rx_wr_ok)  rx_wr_d = rx_wr_q + AW'(1);
    tx_cnt_d  = tx_cnt_q + {{AW{1'b0}}, tx_wr_ok} - {{AW{1'b0}}, tx_pop_ok};
    rx_cnt_d  = rx_cnt_q + {{AW{1'b0}}, rx_wr_ok} - {{AW{1'b0}}, rx_rd_ok};
    tx_ovf_d  = sat_inc(tx_ovf_q, tx_wr && !tx_wr_ok);
    rx_drop_d = sat_inc(rx_drop_q, rx_acc && !rx_wr_ok);
    rx_mis_d  = sat_inc(rx_mis_q, bus.push && !rx_id_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_rd_q   <= '0;
      tx_wr_q   <= '0;
      tx_cnt_q  <= '0;
      rx_rd_q   <= '0;
      rx_wr_q   <= '0;
      rx_cnt_q  <= '0;
      tx_ovf_q  <= '0;
      rx_drop_q <= '0;
      rx_mis_q  <= '0;
    end else begin
      tx_rd_q   <= tx_rd_d;
      tx_wr_q   <= tx_wr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_rd_q   <= rx_rd_d;
      rx_wr_q   <= rx_wr_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_drop_q <= rx_drop_d;
      rx_mis_q  <= rx_mis_d;
    end
  end

  // Storage is not reset; occupancy counts decide what is visible.
  always_ff @(posedge clk) begin
    if (tx_wr_ok && !reset) tx_mem[tx_wr_q] <= tx_data;
    if (rx_wr_ok && !reset) rx_mem[rx_wr_q] <= bus.D_push;
  end
endmodule

// File: tb/tb_bus_port_adapter.sv
module tb_bus_port_adapter;
  logic        clk = 1'b0;
  logic        reset;
  logic        tx_wr, rx_rd;
  logic [15:0] tx_data;
  logic        tx_full, rx_valid, rx_full;
  logic [15:0] rx_data, tx_ovf_cnt, rx_drop_cnt, rx_misroute_cnt;
  int          tests = 0;
  int          fails = 0;

  bus_port_adapter_if #(.pckg_sz(16)) bus_if ();

  bus_port_adapter #(.pckg_sz(16), .depth(8), .drv_id(8'h03), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full),
    .tx_ovf_cnt(tx_ovf_cnt), .rx_drop_cnt(rx_drop_cnt), .rx_misroute_cnt(rx_misroute_cnt),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; tx_wr = 0; tx_data = '0; rx_rd = 0;
    bus_if.pop = 0; bus_if.push = 0; bus_if.D_push = '0;
    tick(); tick();
    tests++; if (bus_if.pndng !== 1'b0) begin fails++; $display("FAIL reset_pndng got %b want 0", bus_if.pndng); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    tests++; if (tx_full !== 1'b0 || rx_full !== 1'b0) begin fails++; $display("FAIL reset_full got %b%b want 00", tx_full, rx_full); end
    tests++; if (bus_if.D_pop !== 16'h0 || rx_data !== 16'h0) begin fails++; $display("FAIL reset_data got %h/%h want 0000/0000", bus_if.D_pop, rx_data); end
    tests++; if ({tx_ovf_cnt, rx_drop_cnt, rx_misroute_cnt} !== 48'h0) begin fails++; $display("FAIL reset_cnts got %h/%h/%h want 0", tx_ovf_cnt, rx_drop_cnt, rx_misroute_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_tx_basic();
    tx_wr = 1; tx_data = 16'h0001;
    tick();
    tests++; if (bus_if.pndng !== 1'b1 || bus_if.D_pop !== 16'h0001) begin fails++; $display("FAIL tx_first got pndng=%b D_pop=%h want 1/0001", bus_if.pndng, bus_if.D_pop); end
    tx_data = 16'h0002; tick();
    tx_data = 16'h0003; tick();
    tx_wr = 0; bus_if.pop = 1;
    for (int i = 1; i <= 3; i++) begin
      tests++; if (bus_if.D_pop !== 16'(i)) begin fails++; $display("FAIL tx_pop%0d got %h want %h", i, bus_if.D_pop, 16'(i)); end
      tick();
    end
    tests++; if (bus_if.pndng !== 1'b0 || bus_if.D_pop !== 16'h0) begin fails++; $display("FAIL tx_empty got pndng=%b D_pop=%h want 0/0000", bus_if.pndng, bus_if.D_pop); end
    tick();  // pop while empty must be ignored
    bus_if.pop = 0;
    tests++; if (bus_if.pndng !== 1'b0) begin fails++; $display("FAIL tx_pop_empty got pndng=%b want 0", bus_if.pndng); end
  endtask

  task automatic test_tx_overflow();
    tx_wr = 1;
    for (int i = 0; i < 10; i++) begin
      tx_data = 16'h0100 + 16'(i);
      tick();
      if (i == 7) begin
        tests++; if (tx_full !== 1'b1) begin fails++; $display("FAIL tx_full_after8 got %b want 1", tx_full); end
      end
    end
    tx_wr = 0;
    tests++; if (tx_ovf_cnt !== 16'd2) begin fails++; $display("FAIL tx_ovf_cnt got %0d want 2", tx_ovf_cnt); end
    bus_if.pop = 1;
    for (int i = 0; i < 8; i++) begin
      tests++; if (bus_if.D_pop !== 16'h0100 + 16'(i)) begin fails++; $display("FAIL tx_drain%0d got %h want %h", i, bus_if.D_pop, 16'h0100 + 16'(i)); end
      tick();
    end
    bus_if.pop = 0;
    tests++; if (bus_if.pndng !== 1'b0) begin fails++; $display("FAIL tx_drained got pndng=%b want 0", bus_if.pndng); end
    tx_wr = 1;
    for (int i = 0; i < 8; i++) begin tx_data = 16'h0200 + 16'(i); tick(); end
    tx_data = 16'h02AA; bus_if.pop = 1;
    tick();
    tx_wr = 0; bus_if.pop = 0;
    tests++; if (tx_full !== 1'b1 || tx_ovf_cnt !== 16'd2) begin fails++; $display("FAIL tx_wr_pop_full got full=%b ovf=%0d want 1/2", tx_full, tx_ovf_cnt); end
    bus_if.pop = 1;
    for (int i = 1; i <= 8; i++) begin
      logic [15:0] exp;
      exp = (i == 8) ? 16'h02AA : 16'h0200 + 16'(i);
      tests++; if (bus_if.D_pop !== exp) begin fails++; $display("FAIL tx_refill_drain%0d got %h want %h", i, bus_if.D_pop, exp); end
      tick();
    end
    bus_if.pop = 0;
  endtask

  task automatic test_rx_filter();
    bus_if.push = 1; bus_if.D_push = 16'h03AA;
    tick();
    tests++; if (rx_valid !== 1'b1 || rx_data !== 16'h03AA) begin fails++; $display("FAIL rx_accept got valid=%b data=%h want 1/03aa", rx_valid, rx_data); end
    bus_if.D_push = 16'hFF55; tick();
    bus_if.D_push = 16'h0712; tick();
    bus_if.push = 0;
    tests++; if (rx_misroute_cnt !== 16'd1 || rx_drop_cnt !== 16'd0) begin fails++; $display("FAIL rx_misroute got mis=%0d drop=%0d want 1/0", rx_misroute_cnt, rx_drop_cnt); end
    rx_rd = 1;
    tests++; if (rx_data !== 16'h03AA) begin fails++; $display("FAIL rx_read0 got %h want 03aa", rx_data); end
    tick();
    tests++; if (rx_data !== 16'hFF55) begin fails++; $display("FAIL rx_read1 got %h want ff55", rx_data); end
    tick();
    tests++; if (rx_valid !== 1'b0 || rx_data !== 16'h0) begin fails++; $display("FAIL rx_empty got valid=%b data=%h want 0/0000", rx_valid, rx_data); end
    tick();  // read while empty ignored
    rx_rd = 0;
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL rx_rd_empty got valid=%b want 0", rx_valid); end
  endtask

  task automatic test_rx_full();
    bus_if.push = 1;
    for (int i = 0; i < 8; i++) begin bus_if.D_push = 16'h0300 + 16'(i); tick(); end
    tests++; if (rx_full !== 1'b1) begin fails++; $display("FAIL rx_full got %b want 1", rx_full); end
    bus_if.D_push = 16'h0399; tick();
    tests++; if (rx_drop_cnt !== 16'd1) begin fails++; $display("FAIL rx_drop got %0d want 1", rx_drop_cnt); end
    bus_if.D_push = 16'h0499; tick();
    tests++; if (rx_drop_cnt !== 16'd1 || rx_misroute_cnt !== 16'd2) begin fails++; $display("FAIL rx_mis_full got drop=%0d mis=%0d want 1/2", rx_drop_cnt, rx_misroute_cnt); end
    bus_if.D_push = 16'h03BB; rx_rd = 1; tick();
    bus_if.push = 0; rx_rd = 0;
    tests++; if (rx_full !== 1'b1 || rx_drop_cnt !== 16'd1 || rx_data !== 16'h0301) begin fails++; $display("FAIL rx_push_rd got full=%b drop=%0d data=%h want 1/1/0301", rx_full, rx_drop_cnt, rx_data); end
    rx_rd = 1;
    for (int i = 1; i <= 8; i++) begin
      logic [15:0] exp;
      exp = (i == 8) ? 16'h03BB : 16'h0300 + 16'(i);
      tests++; if (rx_data !== exp) begin fails++; $display("FAIL rx_drain%0d got %h want %h", i, rx_data, exp); end
      tick();
    end
    rx_rd = 0;
  endtask

  task automatic test_wrap();
    logic [15:0] q[$];
    tx_wr = 1; bus_if.pop = 1; tx_data = 16'hA000;  // pop ignored while empty
    tick();
    q.push_back(16'hA000);
    bus_if.pop = 0; tx_data = 16'hA001; tick();
    q.push_back(16'hA001);
    tests++; if (bus_if.D_pop !== 16'hA000) begin fails++; $display("FAIL wrap_empty_wrpop got %h want a000", bus_if.D_pop); end
    bus_if.pop = 1;
    for (int i = 0; i < 20; i++) begin
      tx_data = 16'hB000 + 16'(i);
      tests++; if (bus_if.D_pop !== q[0]) begin fails++; $display("FAIL wrap%0d got %h want %h", i, bus_if.D_pop, q[0]); end
      tick();
      void'(q.pop_front());
      q.push_back(16'hB000 + 16'(i));
    end
    tx_wr = 0;
    while (q.size() > 0) begin
      tests++; if (bus_if.D_pop !== q[0]) begin fails++; $display("FAIL wrap_drain got %h want %h", bus_if.D_pop, q[0]); end
      tick();
      void'(q.pop_front());
    end
    bus_if.pop = 0;
    tests++; if (bus_if.pndng !== 1'b0) begin fails++; $display("FAIL wrap_end got pndng=%b want 0", bus_if.pndng); end
  endtask

  task automatic test_async_reset();
    tx_wr = 1; bus_if.push = 1;
    for (int i = 0; i < 5; i++) begin
      tx_data = 16'hC000 + 16'(i);
      bus_if.D_push = 16'h0300 + 16'(i);
      bus_if.push = (i < 4);
      tick();
    end
    tx_wr = 0; bus_if.push = 0;
    tests++; if (bus_if.pndng !== 1'b1 || rx_valid !== 1'b1) begin fails++; $display("FAIL ar_pre got pndng=%b rx_valid=%b want 1/1", bus_if.pndng, rx_valid); end
    #2 reset = 1'b1;
    #1;
    tests++; if (bus_if.pndng !== 1'b0 || rx_valid !== 1'b0 || bus_if.D_pop !== 16'h0) begin fails++; $display("FAIL ar_immediate got pndng=%b rx_valid=%b D_pop=%h want 0/0/0000", bus_if.pndng, rx_valid, bus_if.D_pop); end
    tests++; if ({tx_ovf_cnt, rx_drop_cnt, rx_misroute_cnt} !== 48'h0) begin fails++; $display("FAIL ar_cnts got %h/%h/%h want 0", tx_ovf_cnt, rx_drop_cnt, rx_misroute_cnt); end
    #1 reset = 1'b0;
    tick();
    tx_wr = 1; tx_data = 16'h0ABC;
    tick();
    tx_wr = 0;
    tests++; if (bus_if.D_pop !== 16'h0ABC || rx_valid !== 1'b0) begin fails++; $display("FAIL ar_after got D_pop=%h rx_valid=%b want 0abc/0", bus_if.D_pop, rx_valid); end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_rx_filter();
    test_rx_full();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bus_port_adapter.md
Name: bus_port_adapter

Overview:
- Per-device endpoint that sits directly on one port of the bus generator/arbiter (bs_gnrtr_n_rbtr).
- TX side: buffers device packets in a FIFO and presents them to the bus through the pndng/pop/D_pop handshake.
- RX side: accepts packets the bus delivers through push/D_push, filters them by destination ID, and buffers them for the device.
- One instance per bus driver port, replacing the behavioural FIFO model used on the bench.

Parameters:
pckg_sz, 16, packet width in bits; bits [pckg_sz-1:pckg_sz-8] hold the destination ID.
depth, 8, entries per FIFO (TX and RX each); power of two, >=2.
drv_id, 0, this port's 8-bit ID.
broadcast, 8'hFF, destination ID accepted by every port.

Ports:
clk  in  1  system clock, all state updates on rising edge.
reset  in  1  asynchronous, active-high; clears all state.
tx_wr  in  1  device writes tx_data into the TX FIFO.
tx_data  in  pckg_sz  packet from device.
tx_full  out  1  TX FIFO holds depth entries.
pndng  out  1  TX FIFO non-empty; to bus.
D_pop  out  pckg_sz  head of TX FIFO (show-ahead); to bus.
pop  in  1  bus consumes the TX head.
push  in  1  bus delivers D_push to this port.
D_push  in  pckg_sz  packet from bus.
rx_rd  in  1  device consumes the RX head.
rx_data  out  pckg_sz  head of RX FIFO (show-ahead).
rx_valid  out  1  RX FIFO non-empty.
rx_full  out  1  RX FIFO holds depth entries.
tx_ovf_cnt  out  16  TX writes dropped because the FIFO was full.
rx_drop_cnt  out  16  RX packets dropped because the FIFO was full.
rx_misroute_cnt  out  16  RX packets dropped because of an ID mismatch.

Behaviour:
- **Reset (asynchronous, immediate):**
  - All pointers, occupancy counts and counters go to 0.
  - pndng=0, rx_valid=0, tx_full=0, rx_full=0, D_pop=0, rx_data=0.
  - Memory contents need not be cleared.
  - Reset mid-operation discards all buffered packets; the first write after reset deasserts is stored at entry 0.
- **FIFO organisation:**
  - Each FIFO uses rd_ptr/wr_ptr of width $clog2(depth), wrapping modulo depth.
  - Occupancy count has width $clog2(depth)+1.
  - full = (count==depth); empty = (count==0).
- **TX data path:**
  - D_pop = pndng ? mem[rd_ptr] : 0.
  - pndng = !empty, combinational from the registered count.
  - Write latency: a tx_wr accepted at edge N raises pndng after edge N (visible in cycle N+1).
- **Pop handshake:**
  - On an edge with pop=1 and pndng=1: rd_ptr advances and count decrements.
  - pop while empty is ignored; no state change.
  - D_pop must stay stable while pndng=1 and pop=0.
- **TX write rules:**
  - tx_wr while not full: store the packet, advance wr_ptr.
  - tx_wr while full without pop in the same cycle: packet dropped, tx_ovf_cnt +1.
  - tx_wr and pop in the same cycle while full: both succeed; count unchanged.
  - tx_wr and pop in the same cycle while empty: the pop is ignored and the write is stored; count=1.
- **RX filtering:**
  - On push, dest = D_push[pckg_sz-1 -: 8].
  - The packet is accepted if dest==drv_id or dest==broadcast.
  - Otherwise it is discarded and rx_misroute_cnt +1.
- **RX storage:**
  - An accepted packet while full, with no rx_rd in the same cycle: discarded, rx_drop_cnt +1.
  - rx_rd while full on the same edge as an accepted push: both succeed.
  - A misrouted packet never increments rx_drop_cnt, even when the FIFO is full.
- **RX read side:**
  - rx_data = rx_valid ? mem[rd_ptr] : 0; rx_valid = !empty.
  - rx_rd while empty is ignored.
- **Counters:**
  - All three counters saturate at 16'hFFFF (no wrap).
  - They are cleared only by reset.
- **Independence:** TX and RX sides share no state and may be active in the same cycle.

Test Plan:
1. **Reset and basic TX:**
   - Stimulus: reset, then write 16'h0001, 16'h0002, 16'h0003 on consecutive cycles.
   - Required: pndng rises the cycle after the first write; D_pop=16'h0001.
   - Three pops return 0001, 0002, 0003 in order, then pndng=0 and D_pop=0.
2. **TX overflow with depth=8:**
   - Write 10 packets with no pops: tx_full=1 after the 8th, tx_ovf_cnt=2.
   - Then drain 8 packets: order preserved, and only the first 8 values appear.
   - Then write+pop on the same edge while full: count stays 8, tx_ovf_cnt unchanged.
3. **RX filtering with drv_id=3:**
   - push D_push=16'h03AA -> accepted, rx_data=16'h03AA.
   - push 16'hFF55 -> accepted (broadcast).
   - push 16'h0712 -> discarded, rx_misroute_cnt=1, rx_valid count unchanged.
4. **RX full:**
   - Fill with 8 accepted pushes, then push 16'h0399: rx_drop_cnt=1.
   - Push 16'h0499 while still full: rx_misroute_cnt +1, rx_drop_cnt stays 1.
   - Push with rx_rd on the same edge: accepted, count stays 8.
5. **Wrap-around:**
   - Run 20 write/pop pairs through TX at occupancy 1-3.
   - Required: data order intact across pointer wrap; count returns to 0 at the end.
6. **Asynchronous reset mid-stream:**
   - Stimulus: assert reset between clock edges with 5 TX and 4 RX entries held.
   - Required: pndng, rx_valid and all counters go to 0 immediately, without waiting for a clock edge.
   - After release, the next write is D_pop's first value.
